// File: rtl/o_star_normalizer.sv
// O* accumulator and normalizer: sums expmul vector pairs into a running
// accumulator, then on the last key tile divides numerator elements by the
// denominator (element 0) one at a time and presents a Q0.7 row downstream.

`ifndef MAX_EMBEDDING_DIM
`define MAX_EMBEDDING_DIM 4
`endif

module o_star_normalizer #(
    parameter int DIM       = `MAX_EMBEDDING_DIM + 1,
    parameter int ACC_W     = 27,
    parameter int OUT_W     = 8,
    parameter int FRAC_BITS = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    vld_in,
    output logic                    rdy_out,
    input  logic signed [ACC_W-1:0] exp_v_in [DIM],
    input  logic signed [ACC_W-1:0] exp_o_in [DIM],
    input  logic                    last_in,
    output logic signed [ACC_W-1:0] o_star_prev_out [DIM],
    output logic                    vld_out,
    input  logic                    rdy_in,
    output logic signed [OUT_W-1:0] o_out [DIM]
);

    localparam int IDX_W = (DIM > 2) ? $clog2(DIM) : 1;
    localparam int CNT_W = $clog2(FRAC_BITS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAC_BITS);

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DIV   = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic signed [ACC_W-1:0] acc [DIM];
    logic [IDX_W-1:0]        idx;
    logic [CNT_W-1:0]        cnt;

    // divider working registers
    logic [ACC_W:0]          rem;
    logic [ACC_W:0]          den;
    logic [FRAC_BITS-1:0]    quo;
    logic                    neg;
    logic                    den_zero_r;
    logic                    sat_r;

    // divider combinational terms
    logic signed [ACC_W-1:0] num;
    logic [ACC_W:0]          num_mag;
    logic                    den_zero;
    logic                    num_sat;
    logic [ACC_W:0]          rem_sh;
    logic                    bit_nxt;
    logic [ACC_W:0]          rem_nxt;
    logic [FRAC_BITS-1:0]    quo_nxt;

    // Saturating add of two accumulator elements: one extra bit of headroom,
    // clamp when the two top bits disagree.
    function automatic logic signed [ACC_W-1:0] sat_sum(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1])
            sat_sum = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            sat_sum = s[ACC_W-1:0];
    endfunction

    // Final Q0.7 element: forced zero, saturated, or the sign-applied magnitude.
    function automatic logic signed [OUT_W-1:0] quot_out(
        input logic [FRAC_BITS-1:0] q,
        input logic                 is_neg,
        input logic                 is_zero,
        input logic                 is_sat
    );
        logic signed [OUT_W-1:0] mag;
        mag = {1'b0, q};
        if (is_zero)
            quot_out = '0;
        else if (is_sat)
            quot_out = is_neg ? {1'b1, {FRAC_BITS{1'b0}}} : {1'b0, {FRAC_BITS{1'b1}}};
        else
            quot_out = is_neg ? -mag : mag;
    endfunction

    // Setup-cycle magnitude/limit checks and one restoring-division step.
    always_comb begin
        num      = acc[idx];
        num_mag  = num[ACC_W-1] ? -{num[ACC_W-1], num} : {num[ACC_W-1], num};
        den_zero = acc[0][ACC_W-1] || (acc[0] == '0);
        num_sat  = !den_zero && (num_mag >= {1'b0, acc[0]});
        rem_sh   = rem << 1;
        bit_nxt  = (rem_sh >= den);
        rem_nxt  = bit_nxt ? (rem_sh - den) : rem_sh;
        quo_nxt  = (quo << 1) | FRAC_BITS'(bit_nxt);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ACCUM;
        else
            state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (vld_in && last_in) state_nxt = DIV;
            DIV:     if ((cnt == LAST_CNT) && (idx == LAST_IDX)) state_nxt = OUT;
            OUT:     if (rdy_in) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        rdy_out = (state == ACCUM);
        vld_out = (state == OUT);
    end

    // Accumulator, element index, iteration counter and output row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= IDX_W'(1);
            cnt <= '0;
            for (int i = 0; i < DIM; i++) begin
                acc[i]   <= '0;
                o_out[i] <= '0;
            end
        end else begin
            case (state)
                ACCUM: begin
                    if (vld_in) begin
                        for (int i = 0; i < DIM; i++)
                            acc[i] <= sat_sum(exp_v_in[i], exp_o_in[i]);
                        if (last_in) begin
                            idx <= IDX_W'(1);
                            cnt <= '0;
                        end
                    end
                end
                DIV: begin
                    if (cnt == LAST_CNT) begin
                        o_out[idx] <= quot_out(quo_nxt, neg, den_zero_r, sat_r);
                        cnt        <= '0;
                        if (idx != LAST_IDX)
                            idx <= idx + IDX_W'(1);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                OUT: begin
                    if (rdy_in)
                        for (int i = 0; i < DIM; i++)
                            acc[i] <= '0;
                end
                default: ;
            endcase
        end
    end

    // Divider datapath: load on the setup cycle, shift-subtract on the rest.
    always_ff @(posedge clk) begin
        if (state == DIV) begin
            if (cnt == '0) begin
                rem        <= num_mag;
                den        <= {1'b0, acc[0]};
                quo        <= '0;
                neg        <= num[ACC_W-1];
                den_zero_r <= den_zero;
                sat_r      <= num_sat;
            end else begin
                rem <= rem_nxt;
                quo <= quo_nxt;
            end
        end
    end

    // Accumulator fed straight back to expmul.
    always_comb begin
        for (int i = 0; i < DIM; i++)
            o_star_prev_out[i] = acc[i];
    end

endmodule
